// File: rtl/imm_decode_pkg.sv
// Shared RISC-V decode definitions: immediate format codes driven by the control
// unit and consumed by the immediate decoder.
package imm_decode_pkg;

    localparam int IMM_XLEN   = 32;
    localparam int IMM_OP_W   = 25;
    localparam int IMM_CTRL_W = 3;

    typedef enum logic [IMM_CTRL_W-1:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    typedef struct packed {
        logic [IMM_XLEN-1:0] imm;
        logic                valid;
    } imm_result_t;

    // Operand bit k corresponds to instruction bit k+7, so inst[31] is op[24].
    function automatic logic [IMM_XLEN-1:0] imm_i(input logic [IMM_OP_W-1:0] op);
        return {{20{op[24]}}, op[24:13]};
    endfunction

    function automatic logic [IMM_XLEN-1:0] imm_s(input logic [IMM_OP_W-1:0] op);
        return {{20{op[24]}}, op[24:18], op[4:0]};
    endfunction

    function automatic logic [IMM_XLEN-1:0] imm_b(input logic [IMM_OP_W-1:0] op);
        return {{19{op[24]}}, op[24], op[0], op[23:18], op[4:1], 1'b0};
    endfunction

    function automatic logic [IMM_XLEN-1:0] imm_u(input logic [IMM_OP_W-1:0] op);
        return {op[24:5], 12'b0};
    endfunction

    function automatic logic [IMM_XLEN-1:0] imm_j(input logic [IMM_OP_W-1:0] op);
        return {{11{op[24]}}, op[24], op[12:5], op[13], op[23:14], 1'b0};
    endfunction

endpackage

// File: rtl/imm_decode_if.sv
// Operand/format request and registered immediate response of the decoder.
interface imm_decode_if;
    import imm_decode_pkg::*;

    logic [IMM_OP_W-1:0]   input_op;
    logic [IMM_CTRL_W-1:0] imm_control;
    logic [IMM_XLEN-1:0]   imm_op;
    logic                  imm_valid;

    modport master (
        output input_op,
        output imm_control,
        input  imm_op,
        input  imm_valid
    );

    modport slave (
        input  input_op,
        input  imm_control,
        output imm_op,
        output imm_valid
    );

endinterface

// File: rtl/imm_decode_extract.sv
// Combinational immediate extraction; unused format codes yield zero with valid low.
module imm_extract
    import imm_decode_pkg::*;
(
    input  logic [IMM_OP_W-1:0]   i_input_op,
    input  logic [IMM_CTRL_W-1:0] i_imm_control,
    output logic [IMM_XLEN-1:0]   o_imm,
    output logic                  o_valid
);

    imm_fmt_e w_fmt;

    assign w_fmt = imm_fmt_e'(i_imm_control);

    always_comb begin
        o_imm   = '0;
        o_valid = 1'b0;
        case (w_fmt)
            IMM_I: begin
                o_imm   = imm_i(i_input_op);
                o_valid = 1'b1;
            end
            IMM_S: begin
                o_imm   = imm_s(i_input_op);
                o_valid = 1'b1;
            end
            IMM_B: begin
                o_imm   = imm_b(i_input_op);
                o_valid = 1'b1;
            end
            IMM_U: begin
                o_imm   = imm_u(i_input_op);
                o_valid = 1'b1;
            end
            IMM_J: begin
                o_imm   = imm_j(i_input_op);
                o_valid = 1'b1;
            end
            default: begin
                o_imm   = '0;
                o_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_decode.sv
// Immediate decoder: combinational extraction followed by a single output register,
// giving one-cycle latency with synchronous active-high reset.
module imm_decode
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    imm_decode_if.slave   bus
);

    logic [IMM_XLEN-1:0] w_imm;
    logic                w_valid;
    logic [XLEN-1:0]     r_imm_op;
    logic                r_imm_valid;

    imm_extract u_extract (
        .i_input_op    (bus.input_op),
        .i_imm_control (bus.imm_control),
        .o_imm         (w_imm),
        .o_valid       (w_valid)
    );

    // Register loads every cycle; reset wins over any in-flight decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_imm_op    <= '0;
            r_imm_valid <= 1'b0;
        end else begin
            r_imm_op    <= w_imm;
            r_imm_valid <= w_valid;
        end
    end

    assign bus.imm_op    = r_imm_op;
    assign bus.imm_valid = r_imm_valid;

endmodule

// File: tb/tb_imm_decode.sv
// Directed-vector bench for imm_decode with a queue-based scoreboard.
module tb_imm_decode;
    import imm_decode_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] imm;
        logic        valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_decode_if dec_if ();

    imm_decode #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dec_if)
    );

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic apply(input string nm, input logic r, input logic [31:0] inst,
                         input logic [2:0] ctl, input logic [31:0] e_imm, input logic e_v);
        exp_t e;
        @(negedge clk);
        rst                = r;
        dec_if.input_op    = inst[31:7];
        dec_if.imm_control = ctl;
        e.name  = nm;
        e.imm   = e_imm;
        e.valid = e_v;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge with an outstanding expectation produces one comparison.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (dec_if.imm_op !== e.imm || dec_if.imm_valid !== e.valid) begin
                    n_miss++;
                    $display("FAIL %s: got imm_op=%h imm_valid=%b, expected imm_op=%h imm_valid=%b",
                             e.name, dec_if.imm_op, dec_if.imm_valid, e.imm, e.valid);
                end
            end
        end
    end

    initial begin
        int waited;
        dec_if.input_op    = '0;
        dec_if.imm_control = 3'b001;

        apply("reset",        1'b1, 32'h07B00013, 3'b001, 32'h00000000, 1'b0);
        apply("i_pos",        1'b0, 32'h07B00013, 3'b001, 32'h0000007B, 1'b1);
        apply("s_pos",        1'b0, 32'h140020A3, 3'b010, 32'h00000141, 1'b1);
        apply("b_pos",        1'b0, 32'h00000263, 3'b011, 32'h00000004, 1'b1);
        apply("u_pos",        1'b0, 32'h0A455037, 3'b100, 32'h0A455000, 1'b1);
        apply("j_neg",        1'b0, 32'hFE9FF0EF, 3'b101, 32'hFFFFFFE8, 1'b1);
        apply("none_110",     1'b0, 32'hFE9FF0EF, 3'b110, 32'h00000000, 1'b0);
        apply("i_neg",        1'b0, 32'hFFF00093, 3'b001, 32'hFFFFFFFF, 1'b1);
        apply("none_000",     1'b0, 32'hFFF00093, 3'b000, 32'h00000000, 1'b0);
        apply("s_neg",        1'b0, 32'hFE112E23, 3'b010, 32'hFFFFFFFC, 1'b1);
        apply("b_neg",        1'b0, 32'hFE000EE3, 3'b011, 32'hFFFFFFFC, 1'b1);
        apply("u_top",        1'b0, 32'hFFFFF0B7, 3'b100, 32'hFFFFF000, 1'b1);
        apply("none_111",     1'b0, 32'hFFFFF0B7, 3'b111, 32'h00000000, 1'b0);
        apply("j_pos",        1'b0, 32'h0080006F, 3'b101, 32'h00000008, 1'b1);
        // Same operand, different format: result must follow the new pair.
        apply("u_as_i",       1'b0, 32'h0A455037, 3'b001, 32'h000000A4, 1'b1);
        apply("pre_rst",      1'b0, 32'h07B00013, 3'b001, 32'h0000007B, 1'b1);
        apply("rst_mid",      1'b1, 32'hFE9FF0EF, 3'b101, 32'h00000000, 1'b0);
        apply("rst_mid2",     1'b1, 32'h140020A3, 3'b010, 32'h00000000, 1'b0);
        apply("post_rst",     1'b0, 32'h0A455037, 3'b100, 32'h0A455000, 1'b1);
        apply("post_rst_j",   1'b0, 32'hFE9FF0EF, 3'b101, 32'hFFFFFFE8, 1'b1);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/imm_decode.md
IMM_DECODE -- requirements
Module: imm_decode

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning immediate output width; only 32 is supported.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port input_op  input  25  instruction bits [31:7]; input_op[k] = inst[k+7].
REQ-005 The block SHALL have port imm_control  input  3  immediate format select.
REQ-006 The block SHALL have port imm_op  output  32  decoded, sign-extended immediate (registered).
REQ-007 The block SHALL have port imm_valid  output  1  high when imm_op holds a decode of a legal format code.

Function
REQ-008 The block SHALL decode imm_control as: 3'b001 I, 3'b010 S, 3'b011 B, 3'b100 U, 3'b101 J; 3'b000, 3'b110 and 3'b111 are "none".
REQ-009 For I-type, the immediate SHALL be sign-extend(input_op[24:13]), i.e. inst[31:20].
REQ-010 For S-type, the immediate SHALL be sign-extend({input_op[24:18], input_op[4:0]}), i.e. {inst[31:25], inst[11:7]}.
REQ-011 For B-type, the immediate SHALL be sign-extend({input_op[24], input_op[0], input_op[23:18], input_op[4:1], 1'b0}), a 13-bit value with bit 0 forced to 0.
REQ-012 For U-type, the immediate SHALL be {input_op[24:5], 12'b0}, i.e. {inst[31:12], 12'b0}, with no further extension.
REQ-013 For J-type, the immediate SHALL be sign-extend({input_op[24], input_op[12:5], input_op[13], input_op[23:14], 1'b0}), a 21-bit value with bit 0 forced to 0.
REQ-014 For every sign-extended format, the sign bit SHALL be input_op[24] (inst[31]), replicated into all upper bits.
REQ-015 For "none" codes, the next imm_op SHALL be 32'h0 and the next imm_valid SHALL be 0.
REQ-016 For legal codes, the next imm_valid SHALL be 1.
REQ-017 Latency SHALL be exactly one clock: inputs sampled at rising edge N appear on imm_op/imm_valid after edge N.
REQ-018 Outputs SHALL be updated on every clock; there is no enable and no handshake.
REQ-019 The decode SHALL be purely a function of the current input_op/imm_control, with no dependence on earlier inputs.
REQ-020 When format and operand change on the same edge, the output SHALL reflect the new pair only.

Reset
REQ-021 While rst=1 at a rising edge, imm_op SHALL become 32'h0 and imm_valid 0, regardless of other inputs.
REQ-022 Reset asserted mid-stream SHALL discard the in-flight decode; the first post-reset output SHALL be the decode of inputs sampled at the first edge with rst=0.
REQ-023 The block SHALL contain no asynchronous reset paths.

Structure
REQ-024 The imm_control format encodings (IMM_NONE=0, IMM_I=1, IMM_S=2, IMM_B=3, IMM_U=4, IMM_J=5) SHALL be constants in the shared RISC-V decode package, used by both this block and the control unit.
REQ-025 The combinational extraction SHALL be a sub-module imm_extract (input_op, imm_control -> 32-bit immediate, valid); imm_decode SHALL add only the output register stage.

Verification
REQ-026 I-type test: input_op = 32'h07B00013[31:7], imm_control = 001 -> imm_op = 32'h0000007B and imm_valid = 1 one cycle later.
REQ-027 S-type test: input_op = 32'h140020A3[31:7], imm_control = 010 -> imm_op = 32'h00000141.
REQ-028 B-type test: input_op = 32'h00000263[31:7], imm_control = 011 -> imm_op = 32'h00000004.
REQ-029 U-type test: input_op = 32'h0A455037[31:7], imm_control = 100 -> imm_op = 32'h0A455000.
REQ-030 J-type test: input_op = 32'hFE9FF0EF[31:7], imm_control = 101 -> imm_op = 32'hFFFFFFE8 (-24).
REQ-031 None and reset test: imm_control = 110 with any operand -> imm_op = 0 and imm_valid = 0. Then rst=1 during a valid stream -> both outputs are 0 after the edge, and decoding resumes one cycle after rst drops.
